// File: rtl/bin_frame_serializer_if.sv
`default_nettype none
// ============================================================================
// Module      : bin_frame_serializer_if
// Description : Frame-input and MAC stream bundle for bin_frame_serializer.
// Revision    : 1.0  initial release
// ============================================================================
interface bin_frame_serializer_if #(
  parameter int N     = 16,
  parameter int N_OUT = 8,
  parameter int BINS  = 4
);
  localparam int W = BINS * N / N_OUT;

  logic                    in_valid;
  logic [W-1:0][N_OUT-1:0] in_data;
  logic [N_OUT-1:0]        m_data;
  logic                    m_valid;
  logic                    m_ready;
  logic                    m_last;

  // master: the serializer itself (drives the MAC stream)
  modport master (
    input  in_valid, in_data, m_ready,
    output m_data, m_valid, m_last
  );

  // slave: frame source plus MAC side
  modport slave (
    output in_valid, in_data, m_ready,
    input  m_data, m_valid, m_last
  );
endinterface
`default_nettype wire

// File: rtl/bin_frame_serializer.sv
`default_nettype none
// ============================================================================
// Module      : bin_frame_serializer
// Description : Captures a W-word frame and streams it word-by-word to a MAC.
//               Define BIN_FRAME_SEQ_HDR_EN to prefix each frame with a 32-bit
//               sequence number.
// Revision    : 1.0  initial release
// ============================================================================
module bin_frame_serializer #(
  parameter int N     = 16,
  parameter int N_OUT = 8,
  parameter int BINS  = 4
) (
  input  wire logic              clk,
  input  wire logic              rst,
  bin_frame_serializer_if.master bus,
  output logic                   busy,
  output logic                   overflow
);
  localparam int W  = BINS * N / N_OUT;
  localparam int IW = (W > 1) ? $clog2(W) : 1;

`ifdef BIN_FRAME_SEQ_HDR_EN
  localparam int HW  = 32 / N_OUT;
  localparam int HIW = (HW > 1) ? $clog2(HW) : 1;
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HDR   = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_START = S_HDR;
  logic [1:0] r_state;
  logic [31:0]    r_seq;
  logic [HIW-1:0] r_hidx;
  logic [31:0]    w_seq_sh;
`else
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_DATA  = 1'b1;
  localparam logic [0:0] S_START = S_DATA;
  logic [0:0] r_state;
`endif

  logic [W-1:0][N_OUT-1:0] r_hold;
  logic [IW-1:0]           r_idx;
  logic                    r_ovf;
  logic                    w_valid;
  logic                    w_xfer;
  logic                    w_final;

  // Outputs decode purely from registers, so they stay stable under backpressure.
  assign w_valid = (r_state != S_IDLE);
  assign w_xfer  = w_valid & bus.m_ready;
  assign w_final = (r_state == S_DATA) && (r_idx == IW'(W - 1));

`ifdef BIN_FRAME_SEQ_HDR_EN
  assign w_seq_sh = r_seq << (N_OUT * int'(r_hidx));
`endif

  always_comb begin
    bus.m_data = '0;
    if (r_state == S_DATA) begin
      bus.m_data = r_hold[r_idx];
    end
`ifdef BIN_FRAME_SEQ_HDR_EN
    else if (r_state == S_HDR) begin
      bus.m_data = w_seq_sh[31 -: N_OUT];
    end
`endif
  end

  assign bus.m_valid = w_valid;
  assign bus.m_last  = w_final;
  assign busy        = w_valid;
  assign overflow    = r_ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_hold  <= '0;
      r_idx   <= '0;
      r_ovf   <= 1'b0;
`ifdef BIN_FRAME_SEQ_HDR_EN
      r_seq   <= '0;
      r_hidx  <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.in_valid) begin
            r_hold  <= bus.in_data;
            r_idx   <= '0;
`ifdef BIN_FRAME_SEQ_HDR_EN
            r_hidx  <= '0;
`endif
            r_state <= S_START;
          end
        end
`ifdef BIN_FRAME_SEQ_HDR_EN
        S_HDR: begin
          if (bus.in_valid) begin
            r_ovf <= 1'b1;
          end
          if (w_xfer) begin
            if (r_hidx == HIW'(HW - 1)) begin
              r_state <= S_DATA;
            end else begin
              r_hidx <= r_hidx + HIW'(1);
            end
          end
        end
`endif
        S_DATA: begin
          if (w_xfer && w_final) begin
`ifdef BIN_FRAME_SEQ_HDR_EN
            r_seq <= r_seq + 32'd1;
`endif
            // A frame arriving with the final transfer restarts without a gap.
            if (bus.in_valid) begin
              r_hold  <= bus.in_data;
              r_idx   <= '0;
`ifdef BIN_FRAME_SEQ_HDR_EN
              r_hidx  <= '0;
`endif
              r_state <= S_START;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            if (bus.in_valid) begin
              r_ovf <= 1'b1;
            end
            if (w_xfer) begin
              r_idx <= r_idx + IW'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_bin_frame_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bin_frame_serializer
// Description : Self-checking bench for bin_frame_serializer (word-queue model).
// Revision    : 1.0  initial release
// ============================================================================
module tb_bin_frame_serializer;
  localparam int N     = 16;
  localparam int N_OUT = 8;
  localparam int BINS  = 4;
  localparam int W     = BINS * N / N_OUT;
`ifdef BIN_FRAME_SEQ_HDR_EN
  localparam int HW = 32 / N_OUT;
`else
  localparam int HW = 0;
`endif

  typedef struct {
    logic [N_OUT-1:0] d;
    bit               l;
  } wd_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  logic overflow;
  int   checks = 0;
  int   errors = 0;

  wd_t              mq[$];
  logic [31:0]      mseq = '0;
  bit               movf = 1'b0;
  bit               seq_load = 1'b0;
  logic [N_OUT-1:0] got[$];
  bit               pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  bin_frame_serializer_if #(.N(N), .N_OUT(N_OUT), .BINS(BINS)) bus ();

  bin_frame_serializer #(.N(N), .N_OUT(N_OUT), .BINS(BINS)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.master),
    .busy     (busy),
    .overflow (overflow)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0][N_OUT-1:0] mk(input logic [N_OUT-1:0] base);
    logic [W-1:0][N_OUT-1:0] r;
    for (int i = 0; i < W; i++) r[i] = base + N_OUT'(i);
    return r;
  endfunction

  // Model: the stream is a queue of pending words; a frame is accepted only
  // when nothing is pending or its last word leaves in the same cycle.
  initial begin
    bit was_empty;
    bit fin;
    forever begin
      @(posedge clk);
      if (rst) begin
        mq.delete();
        movf = 1'b0;
        mseq = '0;
      end else begin
        was_empty = (mq.size() == 0);
        fin = 1'b0;
        if (!was_empty && bus.m_ready) begin
          fin = mq[0].l;
          void'(mq.pop_front());
          if (fin) mseq = mseq + 32'd1;
        end
        if (seq_load) mseq = 32'hFFFF_FFFF;
        if (bus.in_valid) begin
          if (was_empty || fin) begin
            for (int k = 0; k < HW; k++) mq.push_back('{d: mseq[31 - k*N_OUT -: N_OUT], l: 1'b0});
            for (int i = 0; i < W; i++) mq.push_back('{d: bus.in_data[i], l: (i == W - 1)});
          end else begin
            movf = 1'b1;
          end
        end
      end
    end
  end

  // Transfer log for per-frame content checks.
  initial forever begin
    @(posedge clk);
    if (!rst && bus.m_valid && bus.m_ready) got.push_back(bus.m_data);
  end

  // Cycle-by-cycle compare against the model.
  initial begin
    logic [N_OUT-1:0] ed;
    bit               el;
    forever begin
      @(negedge clk);
      ed = '0;
      el = 1'b0;
      if (mq.size() != 0) begin
        ed = mq[0].d;
        el = mq[0].l;
      end
      chk("m_valid", bus.m_valid, mq.size() != 0);
      chk("m_data", bus.m_data, ed);
      chk("m_last", bus.m_last, el);
      chk("busy", busy, mq.size() != 0);
      chk("overflow", overflow, movf);
    end
  end

  task automatic send(input logic [N_OUT-1:0] base);
    bus.in_data  = mk(base);
    bus.in_valid = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string nm, input bit bp);
    int n;
    n = 0;
    while (busy && n < 100) begin
      if (bp) bus.m_ready = pat[n % 4];
      @(negedge clk);
      n++;
    end
    bus.m_ready = 1'b1;
    chk({nm, "_drained"}, busy, 1'b0);
  endtask

  task automatic check_frame(input string nm, input int off, input logic [N_OUT-1:0] base);
    for (int i = 0; i < W; i++) begin
      if (off + HW + i < got.size())
        chk({nm, "_word"}, got[off + HW + i], base + N_OUT'(i));
      else
        chk({nm, "_missing"}, off + HW + i, got.size());
    end
  endtask

  task automatic wait_data(input string nm, input logic [N_OUT-1:0] v);
    int n;
    n = 0;
    while (!(bus.m_valid && bus.m_data == v && n > HW) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_reached"}, n < 100, 1'b1);
  endtask

  initial begin
    int n;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.m_ready  = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_m_valid", bus.m_valid, 1'b0);
    chk("rst_m_data", bus.m_data, 0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_overflow", overflow, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    // Idle flow
    got.delete();
    send(8'h00);
    chk("t1_first_valid", bus.m_valid, 1'b1);
    chk("t1_first_data", bus.m_data, 8'h00);
    drain("t1", 1'b0);
    chk("t1_count", got.size(), W + HW);
    check_frame("t1", 0, 8'h00);

    // Backpressure 1,0,0,1
    got.delete();
    send(8'h20);
    drain("t2", 1'b1);
    chk("t2_count", got.size(), W + HW);
    check_frame("t2", 0, 8'h20);

    // Back-to-back
    got.delete();
    send(8'h00);
    n = 0;
    while (!(bus.m_valid && bus.m_last) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t3_last_reached", n < 100, 1'b1);
    send(8'h10);
    chk("t3_no_gap", bus.m_valid, 1'b1);
    chk("t3_overflow", overflow, 1'b0);
`ifndef BIN_FRAME_SEQ_HDR_EN
    chk("t3_next_word", bus.m_data, 8'h10);
`endif
    drain("t3", 1'b0);
    chk("t3_count", got.size(), 2 * (W + HW));
    check_frame("t3a", 0, 8'h00);
    check_frame("t3b", W + HW, 8'h10);

    // Drop while word 3 is held
    got.delete();
    send(8'h30);
    wait_data("t4", 8'h33);
    bus.m_ready = 1'b0;
    send(8'hA0);
    chk("t4_overflow", overflow, 1'b1);
    chk("t4_held", bus.m_data, 8'h33);
    bus.m_ready = 1'b1;
    drain("t4", 1'b0);
    chk("t4_count", got.size(), W + HW);
    check_frame("t4", 0, 8'h30);
    chk("t4_sticky", overflow, 1'b1);

    // Reset mid-frame
    send(8'h40);
    wait_data("t5", 8'h42);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t5_valid", bus.m_valid, 1'b0);
    chk("t5_overflow", overflow, 1'b0);
    got.delete();
    send(8'h50);
`ifdef BIN_FRAME_SEQ_HDR_EN
    chk("t5_first", bus.m_data, 8'h00);
`else
    chk("t5_first", bus.m_data, 8'h50);
`endif
    drain("t5", 1'b0);
    check_frame("t5", 0, 8'h50);

`ifdef BIN_FRAME_SEQ_HDR_EN
    chk("hdr_seq0", {got[0], got[1], got[2], got[3]}, 32'h0000_0000);
    for (int f = 1; f <= 2; f++) begin
      got.delete();
      send(8'h60);
      drain("hdr", 1'b0);
      chk("hdr_seq", {got[0], got[1], got[2], got[3]}, f);
    end
    force dut.r_seq = 32'hFFFF_FFFF;
    seq_load = 1'b1;
    @(negedge clk);
    release dut.r_seq;
    seq_load = 1'b0;
    got.delete();
    send(8'h70);
    drain("hdr_max", 1'b0);
    chk("hdr_max", {got[0], got[1], got[2], got[3]}, 32'hFFFF_FFFF);
    got.delete();
    send(8'h80);
    drain("hdr_wrap", 1'b0);
    chk("hdr_wrap", {got[0], got[1], got[2], got[3]}, 32'h0000_0000);
`endif

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire

// File: doc/bin_frame_serializer.md
BIN_FRAME_SERIALIZER -- requirements
Module: bin_frame_serializer

Interface
REQ-001 SHALL have parameter N, default 16: bit width of one averaged bin word.
REQ-002 SHALL have parameter N_OUT, default 8: width of one output word; N SHALL be an integer multiple of N_OUT.
REQ-003 SHALL have parameter BINS, default 4: bins per frame; W = BINS*N/N_OUT output words per frame (8 at defaults).
REQ-004 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port rst  input  1  synchronous active-high reset.
REQ-006 SHALL have port in_valid  input  1  one-cycle pulse marking in_data as a complete frame.
REQ-007 SHALL have port in_data  input  [W-1:0][N_OUT-1:0]  packed frame; element 0 is sent first.
REQ-008 SHALL have port m_data  output  N_OUT  stream word to the Ethernet MAC.
REQ-009 SHALL have port m_valid  output  1  m_data is valid.
REQ-010 SHALL have port m_ready  input  1  MAC accepts the word; a transfer occurs when m_valid and m_ready are both high.
REQ-011 SHALL have port m_last  output  1  high with the final word of a frame.
REQ-012 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-013 SHALL have port overflow  output  1  sticky: a frame was dropped.

Function
REQ-014 SHALL implement states IDLE, HDR (only when the REQ-026 macro is defined) and DATA.
REQ-015 In IDLE, in_valid high SHALL capture in_data into a W-word holding register, zero the word index and enter HDR if enabled, else DATA.
REQ-016 m_valid SHALL rise the cycle after capture; capture-to-first-word latency is exactly 1 cycle.
REQ-017 In DATA, m_data SHALL equal held word [index]; the index SHALL advance only on a transfer.
REQ-018 While m_valid is high and m_ready is low, m_data, m_last and m_valid SHALL hold stable.
REQ-019 m_last SHALL be high only while the final frame word (index W-1) is presented.
REQ-020 On transfer of the final word: enter IDLE, or, if in_valid is high in that same cycle, capture the new frame and restart with m_valid remaining high (gapless back-to-back).
REQ-021 in_valid high in any other non-IDLE cycle SHALL be ignored, the in-flight frame SHALL be unaffected, and overflow SHALL be set.
REQ-022 m_valid SHALL be low in IDLE; m_data SHALL be 0 when m_valid is low.
REQ-023 m_ready SHALL have no effect while m_valid is low.

Reset
REQ-024 rst high SHALL force on the next edge: state IDLE, index 0, holding register 0, m_valid 0, m_last 0, m_data 0, busy 0, overflow 0, sequence counter 0.
REQ-025 rst asserted mid-frame SHALL abandon the frame with no further words emitted; rst SHALL take precedence over in_valid in the same cycle.

Configuration
REQ-026 Macro BIN_FRAME_SEQ_HDR_EN defined: each frame SHALL be preceded by a 32-bit sequence number sent as 32/N_OUT words (4 at defaults), MSB first, in state HDR, then DATA; m_last applies only to the final data word.
REQ-027 The 32-bit sequence counter SHALL start at 0, increment by 1 when a frame's final word transfers, and wrap from 0xFFFFFFFF to 0; dropped frames do not increment it.
REQ-028 Macro undefined: HDR state, counter and header words SHALL not exist; frames are W words only.

Verification
REQ-029 Idle flow: m_ready=1, one in_valid with in_data words 0x00..0x07 -> m_valid high cycles 2..9, m_data 0x00..0x07 in order, m_last only on 0x07, busy low afterwards.
REQ-030 Backpressure: m_ready toggling 1,0,0,1 -> each word held stable while m_ready=0, all 8 words delivered exactly once in order.
REQ-031 Back-to-back: second in_valid (words 0x10..0x17) in the cycle 0x07 transfers -> 0x10 presented on the next cycle, no m_valid gap, overflow stays 0.
REQ-032 Drop: in_valid while word 3 is held with m_ready=0 -> current frame completes unchanged, overflow=1 until rst.
REQ-033 Reset mid-frame: rst pulsed after word 2 -> m_valid=0 next cycle, overflow=0, next frame starts at word 0 (header 0x00000000 if enabled).
REQ-034 With BIN_FRAME_SEQ_HDR_EN: three frames -> headers 00 00 00 00, 00 00 00 01, 00 00 00 02 before each data block; counter forced to 0xFFFFFFFF -> next header FF FF FF FF, following header 00 00 00 00.
